// File: rtl/debug_prof_pkg.sv
// Shared types and bit positions for the frame profiler and its debug word.
package debug_prof_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SEL_STATUS = 2'd0,
      SEL_MIN    = 2'd1,
      SEL_MAX    = 2'd2,
      SEL_LIVE   = 2'd3
   } sel_t;

   // Status bits of the SEL_STATUS word
   localparam int unsigned BIT_RUNNING = 31;
   localparam int unsigned BIT_OVERRUN = 30;
   localparam int unsigned BIT_STRAY   = 29;
   localparam int unsigned BIT_SAT     = 28;

   // Field slots inside the 32-bit debug word
   localparam int unsigned FIELD_W    = 24;
   localparam int unsigned FRAMES_LSB = 24;
   localparam int unsigned FRAMES_W   = 8;

endpackage

// File: rtl/debug_sat_counter.sv
// Saturating cycle counter: loads to 1, increments on enable, stops at all-ones.
module debug_sat_counter #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   assign sat = &cnt;

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(1);
      end else if (inc && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/debug_frame_profiler.sv
// Measures start-to-done cycle counts of the compute engine, keeps last/min/max/frame
// statistics with sticky error flags, and drives a selectable 32-bit word to the debug PIO.
module debug_frame_profiler
   import debug_prof_pkg::*;
#(
   parameter int CNT_W   = 24,
   parameter int FRAME_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        done,
   input  logic        clear,
   input  logic [1:0]  sel,
   output logic [31:0] debug_out
);

   state_t             state, state_nxt;
   logic               cnt_load, cnt_inc, frame_end, set_overrun, set_stray;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_sat;

   logic [CNT_W-1:0]   stat_last, stat_min, stat_max;
   logic [FRAME_W-1:0] frames;
   logic               overrun, stray, sat;
   logic [31:0]        word;

   debug_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .inc   (cnt_inc),
      .cnt   (cnt),
      .sat   (cnt_sat)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nxt   = state;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;
      frame_end   = 1'b0;
      set_overrun = 1'b0;
      set_stray   = 1'b0;
      case (state)
         IDLE: begin
            set_stray = done;
            if (start) begin
               cnt_load  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            frame_end = done;
            if (start) begin
               // A restart with done completes the frame; without done it abandons it
               cnt_load    = 1'b1;
               set_overrun = !done;
            end else if (done) begin
               state_nxt = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_last <= '0;
         stat_min  <= '1;
         stat_max  <= '0;
         frames    <= '0;
         overrun   <= 1'b0;
         stray     <= 1'b0;
         sat       <= 1'b0;
      end else if (clear) begin
         stat_last <= '0;
         stat_min  <= '1;
         stat_max  <= '0;
         frames    <= '0;
         overrun   <= 1'b0;
         stray     <= 1'b0;
         sat       <= 1'b0;
      end else begin
         if (frame_end) begin
            stat_last <= cnt;
            if (cnt < stat_min) stat_min <= cnt;
            if (cnt > stat_max) stat_max <= cnt;
            frames <= frames + 1'b1;
         end
         overrun <= overrun | set_overrun;
         stray   <= stray | set_stray;
         sat     <= sat | (cnt_sat && state == RUN);
      end
   end

   always_comb begin
      word = '0;
      case (sel_t'(sel))
         SEL_STATUS: begin
            word[BIT_RUNNING]   = (state == RUN);
            word[BIT_OVERRUN]   = overrun;
            word[BIT_STRAY]     = stray;
            word[BIT_SAT]       = sat;
            word[FIELD_W-1:0]   = FIELD_W'(stat_last);
         end
         SEL_MIN:  word[FIELD_W-1:0] = FIELD_W'(stat_min);
         SEL_MAX:  word[FIELD_W-1:0] = FIELD_W'(stat_max);
         SEL_LIVE: begin
            word[FRAMES_LSB +: FRAMES_W] = FRAMES_W'(frames);
            word[FIELD_W-1:0]            = FIELD_W'(cnt);
         end
         default: word = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) debug_out <= '0;
      else       debug_out <= word;
   end

endmodule

// File: doc/debug_frame_profiler.md
# debug_frame_profiler

Cycle-accurate profiler for the boid compute engine: measures clock cycles between the engine's frame `start` and `done` pulses and keeps last/min/max/frame-count statistics. It assembles a selectable 32-bit debug word and drives it straight into the `in_port` of the HPS-readable debug PIO. It sits directly upstream of that PIO, and software reads the result over Avalon.

## Interface
- `CNT_W`, default 24: cycle counter width; legal range 8..24.
- `FRAME_W`, default 8: completed-frame counter width; legal range 1..8.
- `clk`, in, 1: system clock. All logic runs on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle pulse. The engine begins a frame.
- `done`, in, 1: single-cycle pulse. The engine finished a frame.
- `clear`, in, 1: synchronous clear of statistics and sticky flags.
- `sel`, in, 2: selects the word driven on `debug_out`.
- `debug_out`, out, 32: registered debug word, wired to the PIO `in_port`.

## Operation
- **States:** IDLE and RUN. Reset puts the block in IDLE.
- **IDLE:**
  - `start` loads `cnt` to 1 and moves to RUN.
  - `done` without `start` is ignored and sets the sticky `stray` flag.
  - `start` and `done` in the same cycle: `start` wins and `stray` is set.
- **RUN:**
  - `cnt` increments every cycle and saturates at 2^CNT_W−1.
  - Reaching saturation sets the sticky `sat` flag.
- **`done` in RUN:**
  - `last` is set to `cnt`, so a frame with `start` at cycle 0 and `done` at cycle N yields N.
  - `min` and `max` are updated (unsigned compare) and `frames` increments, wrapping modulo 2^FRAME_W.
  - The state returns to IDLE.
- **`start` in RUN without `done`:** the current frame is abandoned (no stats update), the sticky `overrun` flag is set, `cnt` reloads to 1, and the state stays RUN.
- **`start` and `done` together in RUN:** the current frame completes normally, then `cnt` reloads to 1 and the state stays RUN. `overrun` is not set.
- **`clear`:**
  - Resets `last`, `max`, `frames` and all sticky flags to 0, and `min` to all-ones.
  - It does not touch the state or `cnt`.
  - If `clear` coincides with a frame completion, `clear` wins and that frame is discarded.
- **`debug_out` mux** (fields zero-extended to their slots):
  - `sel`=0: {`running`, `overrun`, `stray`, `sat`, 4'b0, `last` in [23:0]}
  - `sel`=1: {8'b0, `min`}
  - `sel`=2: {8'b0, `max`}
  - `sel`=3: {`frames` in [31:24], live `cnt` in [23:0]}
- `running` is 1 in RUN.

## Timing
- **Reset values:**
  - `debug_out` = 0, state = IDLE, `cnt` = 0.
  - `last`, `max`, `frames` and all flags = 0; `min` = all-ones.
- **Latency:**
  - Stats registers update on the edge that samples `done`.
  - `debug_out` reflects them one cycle later (two edges after `done`).
  - A `sel` change is visible on `debug_out` after one cycle.
- **Asynchronous reset mid-frame** abandons the frame immediately. No partial stats are retained.
- **No handshake:** `start`, `done` and `clear` are sampled every cycle and are assumed to be single-cycle pulses. A level held high in RUN is treated as repeated events.
- Software reads through the PIO, which adds its own one-cycle register. The word is stable as long as no frame completes in between.

## Structure
- **Shared package `debug_prof_pkg`:**
  - state enum (IDLE, RUN)
  - `sel` encodings (SEL_STATUS, SEL_MIN, SEL_MAX, SEL_LIVE)
  - status-bit positions (31..28) and field offsets
- **Sub-module `debug_sat_counter`:**
  - CNT_W-bit counter with load-to-1, increment enable and saturation flag output.
  - Instantiated once for `cnt`.
- Everything else lives in `debug_frame_profiler`: FSM, stats registers and output mux.

## Test plan
- **Basic frame:** reset, `start` at cycle 0, `done` at cycle 100. Expect `last`=100, `min`=`max`=100, `frames`=1. `sel`=0 gives 0x0000_0064.
- **Min/max tracking:** three frames of 50, 200 and 120 cycles. Expect `min`=50, `max`=200, `last`=120, `frames`=3.
- **Overrun:** `start` at cycle 0, `start` again at cycle 30, `done` at cycle 70 (40 cycles after the restart). Expect `last`=40, `overrun`=1, `frames`=1.
- **Stray and back-to-back:**
  - `done` in IDLE sets `stray`.
  - `start`+`done` in the same cycle in RUN counts the frame, and the next frame begins at `cnt`=1 without setting `overrun`.
- **Saturation (CNT_W=8):** a 300-cycle frame gives `last`=255 and `sat`=1. `frames` wraps to 0 after 2^FRAME_W frames.
- **Clear and reset:**
  - `clear` coincident with `done` leaves `frames`=0, `min`=all-ones and flags 0.
  - Asserting `reset` mid-frame returns `debug_out`=0 and IDLE.
